pipeline_ctrl: RTL and testbench

//  Parametrised pipeline sequencer for the in-order core: replaces the single global ok-to-proceed AND.

---
 rtl/pipeline_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Purpose
//   Elastic sequencer for the in-order core. Each stage holds at most one
//   entry. An entry moves on when its stage is done and the stage ahead is
//   empty or emptying in the same cycle, so bubbles collapse. A stall never
//   holds back the older stages ahead of it. The block also:
//     - kills younger stages on a flush/redirect,
//     - holds decode on a load-use hazard,
//     - picks the forwarding source for each decode operand,
//     - keeps free-running event counters.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low (0 = reset)
//   stg_done     per stage: the entry has finished its work this cycle
//   stg_rd       per stage: destination register, 5 bits per stage
//   stg_wen      per stage: the entry writes stg_rd
//   stg_load     per stage: the entry is a load
//   dec_rs1/2    decode source registers
//   flush_valid  redirect request
//   flush_stage  stage issuing the redirect; every stage below it is killed
//   stg_valid    registered valid bit per stage
//   stg_adv      per stage: the stage latches a new entry this cycle
//   commit       an entry leaves the last stage this cycle
//   ld_hold      decode is held by a load-use hazard
//   fwd_sel1/2   one-hot forwarding source per operand (all 0 = register file)
//   cnt_*        wrapping event counters: cycles, commits, decode stalls, flushes
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int STAGES    = 5,
   parameter int DEC_STAGE = 1,
   parameter int LOAD_RDY  = 3,
   parameter int CNT_W     = 64,
   localparam int FS_W     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [STAGES-1:0]   stg_done,
   input  logic [STAGES*5-1:0] stg_rd,
   input  logic [STAGES-1:0]   stg_wen,
   input  logic [STAGES-1:0]   stg_load,
   input  logic [4:0]          dec_rs1,
   input  logic [4:0]          dec_rs2,
   input  logic                flush_valid,
   input  logic [FS_W-1:0]     flush_stage,
   output logic [STAGES-1:0]   stg_valid,
   output logic [STAGES-1:0]   stg_adv,
   output logic                commit,
   output logic                ld_hold,
   output logic [STAGES-1:0]   fwd_sel1,
   output logic [STAGES-1:0]   fwd_sel2,
   output logic [CNT_W-1:0]    cnt_cycle,
   output logic [CNT_W-1:0]    cnt_commit,
   output logic [CNT_W-1:0]    cnt_stall,
   output logic [CNT_W-1:0]    cnt_flush
);

   localparam logic [FS_W-1:0]  LAST_STAGE = FS_W'(STAGES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [STAGES-1:0] valid_reg;
   logic [STAGES-1:0] valid_next;
   logic [CNT_W-1:0]  cnt_cycle_reg;
   logic [CNT_W-1:0]  cnt_commit_reg;
   logic [CNT_W-1:0]  cnt_stall_reg;
   logic [CNT_W-1:0]  cnt_flush_reg;

   logic [4:0]        rd_arr [STAGES];
   logic              flush_acc_c;
   logic              ld_hold_c;
   logic [STAGES-1:0] move_c;
   logic              room_c;
   logic [STAGES-1:0] adv_c;
   logic [STAGES-1:0] fwd1_c;
   logic [STAGES-1:0] fwd2_c;
   logic              hit1_c;
   logic              hit2_c;
   logic              fwd_cand_c;
   logic              stall_c;

   // Split the packed destination-register bus into one field per stage.
   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_rd
         assign rd_arr[gi] = stg_rd[5*gi +: 5];
      end
   endgenerate

   // Out-of-range redirect stages are dropped entirely (not even counted).
   assign flush_acc_c = flush_valid & (flush_stage <= LAST_STAGE);

   // Load-use hazard: a load between decode and the first stage that can
   // forward load data, writing one of decode's non-zero sources.
   always_comb begin
      ld_hold_c = 1'b0;
      for (int j = 0; j < STAGES; j++) begin
         if ((j > DEC_STAGE) && (j < LOAD_RDY) && valid_reg[j] && stg_wen[j] &&
             stg_load[j] && (rd_arr[j] != 5'd0) &&
             ((rd_arr[j] == dec_rs1) || (rd_arr[j] == dec_rs2))) begin
            ld_hold_c = 1'b1;
         end
      end
      ld_hold_c = ld_hold_c & valid_reg[DEC_STAGE];
   end

   // Move chain, evaluated oldest stage first: room_c says whether the slot
   // ahead of stage i is free by the end of this cycle (retire is always free).
   always_comb begin
      move_c = '0;
      room_c = 1'b1;
      for (int i = STAGES - 1; i >= 0; i--) begin
         move_c[i] = valid_reg[i] & stg_done[i] & room_c &
                     ~((i == DEC_STAGE) & ld_hold_c);
         room_c    = ~valid_reg[i] | move_c[i];
      end
   end

   // Intake per stage. A flush blocks intake into every stage up to and
   // including the redirecting one. Fetch always restarts on a redirect, so
   // for flush_stage==0 the redirected fetch replaces whatever stage 0 held.
   always_comb begin
      adv_c    = '0;
      adv_c[0] = ~valid_reg[0] | move_c[0];
      for (int i = 1; i < STAGES; i++) begin
         adv_c[i] = move_c[i-1];
      end
      if (flush_acc_c) begin
         for (int i = 1; i < STAGES; i++) begin
            if (i <= int'(flush_stage)) begin
               adv_c[i] = 1'b0;
            end
         end
         adv_c[0] = 1'b1;
      end
   end

   // A stage keeps its entry unless it moves on or is killed by a flush from
   // an older stage; the kill wins over anything moving into it.
   always_comb begin
      valid_next = '0;
      for (int i = 0; i < STAGES; i++) begin
         valid_next[i] = adv_c[i] |
                         (valid_reg[i] & ~move_c[i] &
                          ~(flush_acc_c & (i < int'(flush_stage))));
      end
   end

   // Forwarding: the youngest matching producer past decode. A load that has
   // not yet reached the memory stage cannot supply data and is skipped.
   always_comb begin
      fwd1_c     = '0;
      fwd2_c     = '0;
      hit1_c     = 1'b0;
      hit2_c     = 1'b0;
      fwd_cand_c = 1'b0;
      for (int j = 0; j < STAGES; j++) begin
         fwd_cand_c = (j > DEC_STAGE) && valid_reg[j] && stg_wen[j] &&
                      !(stg_load[j] && (j < LOAD_RDY));
         if (!hit1_c && fwd_cand_c && (dec_rs1 != 5'd0) && (rd_arr[j] == dec_rs1)) begin
            fwd1_c[j] = 1'b1;
            hit1_c    = 1'b1;
         end
         if (!hit2_c && fwd_cand_c && (dec_rs2 != 5'd0) && (rd_arr[j] == dec_rs2)) begin
            fwd2_c[j] = 1'b1;
            hit2_c    = 1'b1;
         end
      end
   end

   // Decode stall: occupied, not moving, and not about to be killed.
   assign stall_c = valid_reg[DEC_STAGE] & ~move_c[DEC_STAGE] &
                    ~(flush_acc_c & (DEC_STAGE < int'(flush_stage)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg      <= '0;
         cnt_cycle_reg  <= '0;
         cnt_commit_reg <= '0;
         cnt_stall_reg  <= '0;
         cnt_flush_reg  <= '0;
      end else begin
         valid_reg     <= valid_next;
         cnt_cycle_reg <= cnt_cycle_reg + CNT_ONE;
         if (move_c[STAGES-1]) begin
            cnt_commit_reg <= cnt_commit_reg + CNT_ONE;
         end
         if (stall_c) begin
            cnt_stall_reg <= cnt_stall_reg + CNT_ONE;
         end
         if (flush_acc_c) begin
            cnt_flush_reg <= cnt_flush_reg + CNT_ONE;
         end
      end
   end

   assign stg_valid  = valid_reg;
   assign stg_adv    = adv_c;
   assign commit     = move_c[STAGES-1];
   assign ld_hold    = ld_hold_c;
   assign fwd_sel1   = fwd1_c;
   assign fwd_sel2   = fwd2_c;
   assign cnt_cycle  = cnt_cycle_reg;
   assign cnt_commit = cnt_commit_reg;
   assign cnt_stall  = cnt_stall_reg;
   assign cnt_flush  = cnt_flush_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Bench for pipeline_ctrl. The reference model tracks which entry id sits in
// which slot. Each cycle it moves ids forward, retires them, kills them on a
// flush and fetches fresh ones. Every expected output is read from that
// occupancy picture: valid, intake (a slot holds a new id), commit (an id
// retired), hazard, forwarding and counters. Directed scenarios come first,
// then randomized traffic with occasional asynchronous reset pulses.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int STAGES = 5;
   localparam int DEC    = 1;
   localparam int LRDY   = 3;
   localparam int CW     = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    stg_done;
   logic [24:0]   stg_rd;
   logic [4:0]    stg_wen;
   logic [4:0]    stg_load;
   logic [4:0]    dec_rs1;
   logic [4:0]    dec_rs2;
   logic          flush_valid;
   logic [2:0]    flush_stage;
   logic [4:0]    stg_valid;
   logic [4:0]    stg_adv;
   logic          commit;
   logic          ld_hold;
   logic [4:0]    fwd_sel1;
   logic [4:0]    fwd_sel2;
   logic [CW-1:0] cnt_cycle;
   logic [CW-1:0] cnt_commit;
   logic [CW-1:0] cnt_stall;
   logic [CW-1:0] cnt_flush;

   pipeline_ctrl #(
      .STAGES    (STAGES),
      .DEC_STAGE (DEC),
      .LOAD_RDY  (LRDY),
      .CNT_W     (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stg_done    (stg_done),
      .stg_rd      (stg_rd),
      .stg_wen     (stg_wen),
      .stg_load    (stg_load),
      .dec_rs1     (dec_rs1),
      .dec_rs2     (dec_rs2),
      .flush_valid (flush_valid),
      .flush_stage (flush_stage),
      .stg_valid   (stg_valid),
      .stg_adv     (stg_adv),
      .commit      (commit),
      .ld_hold     (ld_hold),
      .fwd_sel1    (fwd_sel1),
      .fwd_sel2    (fwd_sel2),
      .cnt_cycle   (cnt_cycle),
      .cnt_commit  (cnt_commit),
      .cnt_stall   (cnt_stall),
      .cnt_flush   (cnt_flush)
   );

   always #5 clk = ~clk;

   // ---------------- reference model state ----------------
   int          occ  [STAGES];   // entry id per slot, -1 = empty
   int          nocc [STAGES];   // occupancy after the coming edge
   bit          goes [STAGES];   // entry in slot leaves it at the coming edge
   int          fresh_id = 0;
   logic [4:0]  e_valid, e_adv, e_fwd1, e_fwd2;
   logic        e_commit, e_hold, e_stall, e_flush;
   logic [63:0] m_cyc, m_com, m_stall, m_flush;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cyc    = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] rd_of(input int j);
      return stg_rd[5*j +: 5];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < STAGES; i++) occ[i] = -1;
      m_cyc   = '0;
      m_com   = '0;
      m_stall = '0;
      m_flush = '0;
   endtask

   task automatic model_eval();
      bit f_ok;
      int f;
      bit exit_free;
      int retired;
      bit found1, found2;
      f_ok = flush_valid && (int'(flush_stage) < STAGES);
      f    = int'(flush_stage);

      e_hold = 1'b0;
      if (occ[DEC] >= 0) begin
         for (int j = DEC + 1; j < LRDY; j++) begin
            if (occ[j] >= 0 && stg_wen[j] && stg_load[j] && rd_of(j) != 5'd0 &&
                (rd_of(j) == dec_rs1 || rd_of(j) == dec_rs2)) e_hold = 1'b1;
         end
      end

      // Which entries leave their slot: the oldest retires if done, every
      // younger one follows when the slot ahead will be free.
      exit_free = 1'b1;
      for (int i = STAGES - 1; i >= 0; i--) begin
         goes[i]   = (occ[i] >= 0) && stg_done[i] && exit_free && !(i == DEC && e_hold);
         exit_free = (occ[i] < 0) || goes[i];
      end

      for (int i = 0; i < STAGES; i++) nocc[i] = -1;
      retired = -1;
      for (int i = 0; i < STAGES; i++) begin
         if (occ[i] >= 0) begin
            if (!goes[i])              nocc[i]   = occ[i];
            else if (i == STAGES - 1)  retired   = occ[i];
            else                       nocc[i+1] = occ[i];
         end
      end
      if (f_ok) begin
         for (int i = 0; i < STAGES; i++) begin
            if (i < f)
               nocc[i] = -1;
            else if (i == f && i > 0)
               nocc[i] = (occ[i] >= 0 && !goes[i]) ? occ[i] : -1;
         end
      end
      if (f_ok || occ[0] < 0 || goes[0]) nocc[0] = fresh_id;

      for (int i = 0; i < STAGES; i++) begin
         e_valid[i] = occ[i] >= 0;
         e_adv[i]   = (nocc[i] >= 0) && (nocc[i] != occ[i]);
      end
      e_commit = retired >= 0;
      e_stall  = (occ[DEC] >= 0) && !goes[DEC] && !(f_ok && DEC < f);
      e_flush  = f_ok;

      e_fwd1 = '0;
      e_fwd2 = '0;
      found1 = 1'b0;
      found2 = 1'b0;
      for (int j = DEC + 1; j < STAGES; j++) begin
         if (occ[j] >= 0 && stg_wen[j] && !(stg_load[j] && j < LRDY)) begin
            if (!found1 && dec_rs1 != 5'd0 && rd_of(j) == dec_rs1) begin
               e_fwd1[j] = 1'b1;
               found1    = 1'b1;
            end
            if (!found2 && dec_rs2 != 5'd0 && rd_of(j) == dec_rs2) begin
               e_fwd2[j] = 1'b1;
               found2    = 1'b1;
            end
         end
      end
   endtask

   task automatic model_apply();
      for (int i = 0; i < STAGES; i++) occ[i] = nocc[i];
      fresh_id++;
      m_cyc   = m_cyc + 64'd1;
      m_com   = m_com + 64'(e_commit);
      m_stall = m_stall + 64'(e_stall);
      m_flush = m_flush + 64'(e_flush);
   endtask

   task automatic compare_now();
      model_eval();
      check_val("valid",      64'(stg_valid), 64'(e_valid));
      check_val("adv",        64'(stg_adv),   64'(e_adv));
      check_val("commit",     64'(commit),    64'(e_commit));
      check_val("ld_hold",    64'(ld_hold),   64'(e_hold));
      check_val("fwd_sel1",   64'(fwd_sel1),  64'(e_fwd1));
      check_val("fwd_sel2",   64'(fwd_sel2),  64'(e_fwd2));
      check_val("cnt_cycle",  cnt_cycle,      m_cyc);
      check_val("cnt_commit", cnt_commit,     m_com);
      check_val("cnt_stall",  cnt_stall,      m_stall);
      check_val("cnt_flush",  cnt_flush,      m_flush);
   endtask

   // Inputs are driven 1 ns after a rising edge; sampling happens 3 ns later.
   task automatic settle();
      #3;
      compare_now();
   endtask

   task automatic advance();
      $display("cyc %0d valid=%b adv=%b commit=%b hold=%b fwd1=%b fwd2=%b flush=%b/%0d",
               n_cyc, stg_valid, stg_adv, commit, ld_hold, fwd_sel1, fwd_sel2,
               flush_valid, flush_stage);
      @(posedge clk);
      model_apply();
      n_cyc++;
      #1;
   endtask

   task automatic cycle_step();
      settle();
      advance();
   endtask

   task automatic set_idle();
      stg_done    = '1;
      stg_wen     = '0;
      stg_load    = '0;
      stg_rd      = '0;
      dec_rs1     = '0;
      dec_rs2     = '0;
      flush_valid = 1'b0;
      flush_stage = '0;
   endtask

   // Short low pulse between edges: state must clear without waiting for a clock.
   task automatic reset_pulse();
      rst = 1'b0;
      #1;
      model_reset();
      compare_now();
      check_val("arst_valid",  64'(stg_valid), 64'd0);
      check_val("arst_cycle",  cnt_cycle,      64'd0);
      check_val("arst_commit", 64'(commit),    64'd0);
      #2;
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0]  fill_exp;
      logic [63:0] base;

      rst = 1'b0;
      set_idle();
      model_reset();
      #2;
      compare_now();
      check_val("rst_adv", 64'(stg_adv), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Fill from empty with every stage done.
      for (int k = 0; k < STAGES; k++) begin
         cycle_step();
         fill_exp = 5'((1 << (k + 1)) - 1);
         check_val("fill_valid", 64'(stg_valid), 64'(fill_exp));
      end
      settle();
      check_val("full_commit", 64'(commit), 64'd1);
      advance();

      // Stage 3 not done for three cycles: younger stages hold, stage 4 drains.
      base     = m_stall;
      stg_done = 5'b10111;
      repeat (3) cycle_step();
      check_val("stall_valid", 64'(stg_valid), 64'(5'b01111));
      check_val("stall_cnt",   cnt_stall,      base + 64'd3);
      stg_done = '1;
      cycle_step();
      check_val("resume_valid", 64'(stg_valid), 64'(5'b11111));

      // Load to x5 in stage 2 while decode reads x5 on rs2.
      stg_wen        = 5'b00100;
      stg_load       = 5'b00100;
      stg_rd[14:10]  = 5'd5;
      dec_rs2        = 5'd5;
      settle();
      check_val("lu_hold", 64'(ld_hold),    64'd1);
      check_val("lu_adv2", 64'(stg_adv[2]), 64'd0);
      advance();
      // The load is now in the memory stage; stage 2 holds the bubble.
      stg_rd         = '0;
      stg_rd[19:15]  = 5'd5;
      stg_wen        = 5'b01000;
      stg_load       = 5'b01000;
      settle();
      check_val("lu_release", 64'(ld_hold),   64'd0);
      check_val("lu_valid",   64'(stg_valid), 64'(5'b11011));
      check_val("lu_fwd2",    64'(fwd_sel2),  64'(5'b01000));
      advance();

      // Two producers of x7: the younger one (stage 2) wins.
      set_idle();
      repeat (STAGES) cycle_step();
      stg_rd[14:10] = 5'd7;
      stg_rd[19:15] = 5'd7;
      stg_wen       = 5'b01100;
      dec_rs1       = 5'd7;
      settle();
      check_val("fwd_young", 64'(fwd_sel1), 64'(5'b00100));
      dec_rs1 = 5'd0;
      settle();
      check_val("fwd_x0", 64'(fwd_sel1), 64'd0);
      advance();

      // Redirect from stage 2 on a full pipe, then an out-of-range one.
      set_idle();
      repeat (STAGES) cycle_step();
      base        = m_flush;
      flush_valid = 1'b1;
      flush_stage = 3'd2;
      cycle_step();
      check_val("flush_valid", 64'(stg_valid), 64'(5'b11001));
      check_val("flush_cnt",   cnt_flush,      base + 64'd1);
      flush_stage = 3'd7;
      cycle_step();
      check_val("flush_ignored", cnt_flush, base + 64'd1);

      // Asynchronous reset mid-stream, then refill restarts on the next edge.
      set_idle();
      repeat (3) cycle_step();
      reset_pulse();
      cycle_step();
      check_val("refill_valid", 64'(stg_valid), 64'd1);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < STAGES; i++) begin
            stg_done[i]      = ($urandom_range(0, 3) != 0);
            stg_rd[5*i +: 5] = 5'($urandom_range(0, 7));
         end
         stg_wen     = 5'($urandom);
         stg_load    = 5'($urandom) & 5'($urandom);
         dec_rs1     = 5'($urandom_range(0, 7));
         dec_rs2     = 5'($urandom_range(0, 7));
         flush_valid = ($urandom_range(0, 9) == 0);
         flush_stage = 3'($urandom);
         if ($urandom_range(0, 199) == 0) reset_pulse();
         cycle_step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
